alt_sv_gbt_tx_pll_dps_ctrl: RTL
===============================

# alt_sv_gbt_tx_pll_dps_ctrl

Dynamic-phase-shift sequencer for the Stratix V TX frame-clock PLL (120 MHz ref, 720 MHz VCO, 40 MHz outputs, DPS subtype). It accepts multi-step phase-shift requests from the TX frame-clock phase aligner. It drives the PLL `phase_en`/`updn`/`cntsel` pins one step at a time and waits for `phase_done` between steps. It also keeps a modulo position count of the shifted output.

## Interface
Parameters:
- `STEP_W`, 8 — width of requested step count.
- `POS_W`, 8 — width of `phase_pos`.
- `STEPS_PER_PERIOD`, 144 — VCO/8 steps per 40 MHz period (25 ns / 173.6 ps).
- `TRACK_CNTSEL`, 0 — counter select whose steps update `phase_pos`.
- `PULSE_CYCLES`, 2 — `phase_en` high time, scanclk cycles (≥1).
- `GAP_CYCLES`, 2 — idle cycles between consecutive steps (≥1).
- `TIMEOUT_CYCLES`, 1024 — max wait for each `phase_done` edge.

Ports:
- `scanclk` in 1 — sole clock; the PLL scan clock.
- `rst` in 1 — asynchronous, active-high reset.
- `req_valid` in 1 — shift request.
- `req_ready` out 1 — controller can accept.
- `req_steps` in STEP_W — number of steps.
- `req_updn` in 1 — 1 = advance, 0 = retard.
- `req_cntsel` in 5 — PLL counter select.
- `pll_locked` in 1 — PLL `locked`; asynchronous to `scanclk`.
- `pll_phase_done` in 1 — PLL `phase_done`; `scanclk` domain.
- `pll_phase_en` out 1 — to PLL.
- `pll_updn` out 1 — to PLL.
- `pll_cntsel` out 5 — to PLL.
- `busy` out 1 — high when not IDLE.
- `done` out 1 — one-cycle pulse when a request completes.
- `err` out 1 — sticky abort flag.
- `phase_pos` out POS_W — position of `TRACK_CNTSEL`, range 0..STEPS_PER_PERIOD-1.

## Operation
- `pll_locked` passes through a 2-FF synchronizer to give `lock_s`.
- `req_ready` = (state==IDLE) & `lock_s`. A request is accepted on `req_valid & req_ready`.
- On accept:
  - Latch steps, updn and cntsel. `pll_updn`/`pll_cntsel` take the new values on the accept edge and hold until the next accept.
  - Clear `err`.
- States:
  - IDLE: if accepted with steps==0, go DONE; if accepted with steps>0, go SETUP.
  - SETUP: 1 cycle, gives cntsel/updn setup before `phase_en`; go ASSERT.
  - ASSERT: `pll_phase_en`=1 for PULSE_CYCLES; go WAIT_LOW.
  - WAIT_LOW: wait for `pll_phase_done`=0; go WAIT_HIGH.
  - WAIT_HIGH: wait for `pll_phase_done`=1. The step is then complete: decrement remaining, update `phase_pos`. If remaining is now 0, go DONE; else go GAP.
  - GAP: GAP_CYCLES cycles; go ASSERT.
  - DONE: `done`=1 for 1 cycle; go IDLE.
- `phase_pos` update happens only when latched cntsel==TRACK_CNTSEL.
  - Up: +1, wrapping STEPS_PER_PERIOD-1 → 0.
  - Down: −1, wrapping 0 → STEPS_PER_PERIOD-1.
- Abort: `lock_s`=0 in any state other than IDLE/DONE.
  - Drop `pll_phase_en` the same edge, set `err`, go IDLE.
  - No `done` pulse. Remaining steps are discarded; `phase_pos` keeps its count of completed steps.
- `req_valid` while busy is ignored (not queued).

## Timing
- Reset values:
  - `pll_phase_en`=0, `pll_updn`=0, `pll_cntsel`=0.
  - `busy`=0, `done`=0, `err`=0, `phase_pos`=0.
  - `req_ready`=0 until `lock_s`=1 (2 cycles after `pll_locked` rises).
- Accept at edge 0: cntsel/updn valid from edge 0, `phase_en` rises at edge 2, falls at edge 2+PULSE_CYCLES.
- Step period = 1 (SETUP, first step only) + PULSE_CYCLES + PLL done latency + 2 edge-detect cycles + GAP_CYCLES (between steps only).
- `done` asserts the cycle after the final WAIT_HIGH exit. `req_ready` returns the cycle after `done`.
- `phase_done` already 0 on entering WAIT_LOW: advance next cycle. Same rule for 1 on entering WAIT_HIGH.
- Reset mid-step: all outputs return to reset values immediately, regardless of PLL state.

## Configuration
- `DPS_CTRL_TIMEOUT_EN` defined:
  - A counter runs in WAIT_LOW/WAIT_HIGH and restarts at each state entry.
  - Reaching TIMEOUT_CYCLES aborts as on lock loss: `err`=1, IDLE, `phase_en`=0.
- Not defined: no counter; the controller waits indefinitely for `phase_done`.

## Test plan
- Reset, `pll_locked`=1, request steps=3, up, cntsel=0; PLL model drops `phase_done` 2 cycles after `phase_en`, raises it 4 cycles later → exactly 3 `phase_en` pulses of 2 cycles, `done` once, `phase_pos`=3, `err`=0.
- With `phase_pos`=0, request 1 step down on cntsel 0 → `phase_pos`=143. Then request 144 steps up → `phase_pos`=143 (full wrap).
- Request steps=0 → no `phase_en`, `done` 2 cycles after accept. Request on cntsel=2 with 5 steps → `phase_pos` unchanged.
- `pll_locked` falls during the second of 4 steps → `phase_en` low within 3 cycles, `err`=1, no `done`, `req_ready`=0 until lock returns. The next accept clears `err`.
- With `DPS_CTRL_TIMEOUT_EN`, PLL model never drops `phase_done` → abort with `err`=1 exactly TIMEOUT_CYCLES after WAIT_LOW entry. Without the macro, still busy after 10×TIMEOUT_CYCLES.
- `req_valid` held high through a 4-step request with different cntsel → second request accepted only after `done`. `pll_cntsel` is unchanged during the first request.

Source files
------------

// File: rtl/alt_sv_gbt_tx_pll_dps_ctrl_if.sv
// Request and PLL-pin bundle for the TX frame-clock PLL dynamic-phase-shift sequencer.
// master: phase aligner plus PLL side (drives requests, locked, phase_done); slave: the sequencer.
interface alt_sv_gbt_tx_pll_dps_ctrl_if #(
  parameter int STEP_W = 8,
  parameter int POS_W  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [STEP_W-1:0] req_steps;
  logic              req_updn;
  logic [4:0]        req_cntsel;
  logic              pll_locked;
  logic              pll_phase_done;
  logic              pll_phase_en;
  logic              pll_updn;
  logic [4:0]        pll_cntsel;
  logic              busy;
  logic              done;
  logic              err;
  logic [POS_W-1:0]  phase_pos;

  modport master (
    output req_valid, req_steps, req_updn, req_cntsel, pll_locked, pll_phase_done,
    input  req_ready, pll_phase_en, pll_updn, pll_cntsel, busy, done, err, phase_pos
  );

  modport slave (
    input  req_valid, req_steps, req_updn, req_cntsel, pll_locked, pll_phase_done,
    output req_ready, pll_phase_en, pll_updn, pll_cntsel, busy, done, err, phase_pos
  );
endinterface

// File: rtl/alt_sv_gbt_tx_pll_dps_ctrl.sv
// Steps the TX frame-clock PLL phase one DPS pulse at a time and tracks the modulo phase position.
// Optional phase_done watchdog is enabled by defining DPS_CTRL_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | waiting for a request (ready only while lock_s)
// SETUP      | one cycle of cntsel/updn setup before phase_en
// ASSERT     | phase_en pulse, PULSE_CYCLES long
// WAIT_LOW   | waiting for phase_done to drop
// WAIT_HIGH  | waiting for phase_done to return; step complete
// GAP        | GAP_CYCLES idle between steps
// DONE       | one-cycle done pulse
module alt_sv_gbt_tx_pll_dps_ctrl #(
  parameter int STEP_W           = 8,
  parameter int POS_W            = 8,
  parameter int STEPS_PER_PERIOD = 144,
  parameter int TRACK_CNTSEL     = 0,
  parameter int PULSE_CYCLES     = 2,
  parameter int GAP_CYCLES       = 2,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input logic                         scanclk,
  input logic                         rst,
  alt_sv_gbt_tx_pll_dps_ctrl_if.slave bus
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > PULSE_CYCLES)
                         ? ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES)
                         : ((PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES);
  localparam int CNT_W = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(STEPS_PER_PERIOD - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ASSERT,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [1:0]        lock_sync;
  logic              lock_s;
  logic              ready;
  logic              accept;
  logic              step_ok;
  logic              abort;
  logic              tmo_hit;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_load;
  logic [STEP_W-1:0] rem;
  logic              phase_en_q;
  logic              updn_q;
  logic [4:0]        cntsel_q;
  logic              err_q;
  logic [POS_W-1:0]  pos_q;

  always_ff @(posedge scanclk or posedge rst) begin
    if (rst) lock_sync <= 2'b00;
    else     lock_sync <= {lock_sync[0], bus.pll_locked};
  end

  assign lock_s = lock_sync[1];
  assign ready  = (state == ST_IDLE) && lock_s;
  assign accept = bus.req_valid && ready;

`ifdef DPS_CTRL_TIMEOUT_EN
  assign tmo_hit = (cnt == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    step_ok  = 1'b0;
    abort    = 1'b0;
    cnt_load = '0;
    case (state)
      ST_IDLE:      if (accept) state_d = (bus.req_steps == '0) ? ST_DONE : ST_SETUP;
      ST_SETUP:     state_d = ST_ASSERT;
      ST_ASSERT:    if (cnt == '0) state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: begin
        if (!bus.pll_phase_done) state_d = ST_WAIT_HIGH;
        else if (tmo_hit)        abort   = 1'b1;
      end
      ST_WAIT_HIGH: begin
        if (bus.pll_phase_done) begin
          step_ok = 1'b1;
          state_d = (rem == STEP_W'(1)) ? ST_DONE : ST_GAP;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end
      ST_GAP:       if (cnt == '0) state_d = ST_ASSERT;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    // Lock loss wins over any step that happens to complete in the same cycle.
    if (!lock_s && (state != ST_IDLE) && (state != ST_DONE)) abort = 1'b1;
    if (abort) begin
      state_d = ST_IDLE;
      step_ok = 1'b0;
    end
    case (state_d)
      ST_ASSERT:                 cnt_load = CNT_W'(PULSE_CYCLES - 1);
      ST_GAP:                    cnt_load = CNT_W'(GAP_CYCLES - 1);
      ST_WAIT_LOW, ST_WAIT_HIGH: cnt_load = CNT_W'(TIMEOUT_CYCLES - 1);
      default:                   cnt_load = '0;
    endcase
  end

  always_ff @(posedge scanclk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rem        <= '0;
      phase_en_q <= 1'b0;
      updn_q     <= 1'b0;
      cntsel_q   <= '0;
      err_q      <= 1'b0;
      pos_q      <= '0;
    end else begin
      state <= state_d;
      if (state_d != state) cnt <= cnt_load;
      else if (cnt != '0)   cnt <= cnt - 1'b1;
      // Registered from the state so the pulse trails ASSERT by one cycle and lands at accept+2.
      phase_en_q <= (state == ST_ASSERT) && !abort;
      if (accept) begin
        rem      <= bus.req_steps;
        updn_q   <= bus.req_updn;
        cntsel_q <= bus.req_cntsel;
        err_q    <= 1'b0;
      end
      if (abort) err_q <= 1'b1;
      if (step_ok) begin
        rem <= rem - 1'b1;
        if (cntsel_q == 5'(TRACK_CNTSEL)) begin
          if (updn_q) pos_q <= (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
          else        pos_q <= (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
        end
      end
    end
  end

  assign bus.req_ready    = ready;
  assign bus.pll_phase_en = phase_en_q;
  assign bus.pll_updn     = updn_q;
  assign bus.pll_cntsel   = cntsel_q;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.done         = (state == ST_DONE);
  assign bus.err          = err_q;
  assign bus.phase_pos    = pos_q;

endmodule
